// File: rtl/top_mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module  : top_mul_share_arb
// Brief   : Round-robin arbiter feeding one shared unsigned multiplier through
//           a stall-able MUL_LATENCY-stage pipeline with a response counter.
// Revision: 1.0
// ============================================================================
module top_mul_share_arb #(
    parameter int NUM_REQ     = 4,
    parameter int A_WIDTH     = 28,
    parameter int B_WIDTH     = 64,
    parameter int P_WIDTH     = 92,
    parameter int MUL_LATENCY = 2
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [P_WIDTH-1:0]           rsp_product,
    output logic [31:0]                  ops_count
);

    localparam int                C_ID_W      = $clog2(NUM_REQ);
    localparam logic [C_ID_W-1:0] C_LAST_INIT = C_ID_W'(NUM_REQ - 1);
    localparam logic [31:0]       C_CNT_MAX   = 32'hFFFF_FFFF;

    logic [C_ID_W-1:0]      last_grant_q, last_grant_d;
    logic [MUL_LATENCY-1:0] valid_q, valid_d;
    logic [C_ID_W-1:0]      id_q [MUL_LATENCY];
    logic [C_ID_W-1:0]      id_d [MUL_LATENCY];
    logic [A_WIDTH-1:0]     a_q, a_d;
    logic [B_WIDTH-1:0]     b_q, b_d;
    logic [31:0]            ops_count_q, ops_count_d;

    logic                   w_rsp_valid;
    logic                   w_advance;
    logic                   w_accept;
    logic                   w_grant_found;
    logic [C_ID_W-1:0]      w_grant_idx;
    logic [NUM_REQ-1:0]     w_req_ready;
    logic [A_WIDTH-1:0]     w_sel_a;
    logic [B_WIDTH-1:0]     w_sel_b;
    logic [P_WIDTH-1:0]     w_mul;
    logic [P_WIDTH-1:0]     w_rsp_product;

    // Reset masks the output valid so nothing leaves while ap_rst is held.
    assign w_rsp_valid = valid_q[MUL_LATENCY-1] && !ap_rst;
    assign w_advance   = !w_rsp_valid || rsp_ready;

    always_comb begin : p_arb
        int                v_idx;
        logic [C_ID_W-1:0] v_sel;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        v_idx         = 0;
        v_sel         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = (int'(last_grant_q) + k) % NUM_REQ;
            v_sel = C_ID_W'(v_idx);
            if (!w_grant_found && req_valid[v_sel]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = v_sel;
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (w_grant_found && w_advance && !ap_rst) begin
            w_req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_accept = |(req_valid & w_req_ready);

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == C_ID_W'(i)) begin
                w_sel_a = req_a[i*A_WIDTH +: A_WIDTH];
                w_sel_b = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    always_comb begin
        valid_d      = valid_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        last_grant_d = last_grant_q;
        ops_count_d  = ops_count_q;
        if (w_advance) begin
            valid_d[0] = w_accept;
            for (int s = 1; s < MUL_LATENCY; s++) begin
                valid_d[s] = valid_q[s-1];
                id_d[s]    = id_q[s-1];
            end
        end
        if (w_accept) begin
            id_d[0]      = w_grant_idx;
            a_d          = w_sel_a;
            b_d          = w_sel_b;
            last_grant_d = w_grant_idx;
        end
        if (w_rsp_valid && rsp_ready && (ops_count_q != C_CNT_MAX)) begin
            ops_count_d = ops_count_q + 32'd1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            valid_q      <= '0;
            last_grant_q <= C_LAST_INIT;
            ops_count_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            last_grant_q <= last_grant_d;
            ops_count_q  <= ops_count_d;
        end
    end

    // Payload registers are qualified by valid_q, so they need no reset.
    always_ff @(posedge ap_clk) begin
        id_q <= id_d;
        a_q  <= a_d;
        b_q  <= b_d;
    end

    // The single shared multiplier sits between stage 0 (operands) and the product stages.
    assign w_mul = P_WIDTH'(a_q) * P_WIDTH'(b_q);

    generate
        if (MUL_LATENCY == 1) begin : g_lat_one
            assign w_rsp_product = w_mul;
        end else begin : g_lat_multi
            logic [P_WIDTH-1:0] prod_q [1:MUL_LATENCY-1];
            logic [P_WIDTH-1:0] prod_d [1:MUL_LATENCY-1];

            always_comb begin
                prod_d = prod_q;
                if (w_advance) begin
                    prod_d[1] = w_mul;
                    for (int s = 2; s < MUL_LATENCY; s++) begin
                        prod_d[s] = prod_q[s-1];
                    end
                end
            end

            always_ff @(posedge ap_clk) begin
                prod_q <= prod_d;
            end

            assign w_rsp_product = prod_q[MUL_LATENCY-1];
        end
    endgenerate

    assign req_ready   = w_req_ready;
    assign rsp_valid   = w_rsp_valid;
    assign rsp_id      = id_q[MUL_LATENCY-1];
    assign rsp_product = w_rsp_product;
    assign ops_count   = ops_count_q;

endmodule
`default_nettype wire
